// File: rtl/adsr_env_mux.sv
// Time-multiplexed multi-voice ADSR envelope generator.
// One shared saturating add/sub datapath services one voice per clock,
// round-robin, and emits a voice-tagged level stream one cycle later.
module adsr_env_mux #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_VOICES = 4,
   parameter int          RETRIGGER  = 1,
   localparam int unsigned VOICE_W   = $clog2(NUM_VOICES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_VOICES-1:0] gate,
   input  logic [DATA_WIDTH-1:0] attack_rate,
   input  logic [DATA_WIDTH-1:0] decay_rate,
   input  logic [DATA_WIDTH-1:0] sustain_level,
   input  logic [DATA_WIDTH-1:0] release_rate,
   output logic                  env_valid,
   output logic [VOICE_W-1:0]    env_voice,
   output logic [DATA_WIDTH-1:0] env_level,
   output logic [NUM_VOICES-1:0] active
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_e;

   // Per-voice storage
   state_e                state_q     [NUM_VOICES];
   logic [DATA_WIDTH-1:0] level_q     [NUM_VOICES];
   logic [NUM_VOICES-1:0] prev_gate_q;
   logic [VOICE_W-1:0]    ptr_q, ptr_d;

   // Registered outputs
   logic                  env_valid_q;
   logic [VOICE_W-1:0]    env_voice_q;
   logic [DATA_WIDTH-1:0] env_level_q;
   logic [NUM_VOICES-1:0] active_q, active_d;

   // Serviced-voice datapath signals
   state_e                cur_state, base_state, nxt_state, svc_state_d;
   logic [DATA_WIDTH-1:0] base_level, start_level, svc_level_d;
   logic [DATA_WIDTH:0]   att_sum, dec_diff, rel_diff;
   logic                  g, rise;

   // Round-robin service pointer, wraps at NUM_VOICES-1
   always_comb begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == VOICE_W'(NUM_VOICES - 1))
         ptr_d = '0;
   end

   // Next state and level of the voice being serviced this cycle
   always_comb begin
      cur_state   = state_q[ptr_q];
      base_state  = cur_state;
      base_level  = level_q[ptr_q];
      g           = gate[ptr_q];
      rise        = g & ~prev_gate_q[ptr_q];

      // A corrupted state encoding is treated as IDLE at level 0.
      case (cur_state)
         ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE: ;
         default: begin
            base_state = ST_IDLE;
            base_level = '0;
         end
      endcase

      nxt_state   = base_state;
      start_level = base_level;
      if (rise) begin
         nxt_state = ST_ATTACK;
         if (RETRIGGER != 0)
            start_level = '0;
      end else if (!g && (base_state == ST_ATTACK || base_state == ST_DECAY ||
                          base_state == ST_SUSTAIN)) begin
         nxt_state = ST_RELEASE;
      end

      att_sum  = {1'b0, start_level} + {1'b0, attack_rate};
      dec_diff = {1'b0, start_level} - {1'b0, decay_rate};
      rel_diff = {1'b0, start_level} - {1'b0, release_rate};

      // The segment action is applied to the start level in the same service.
      svc_state_d = nxt_state;
      svc_level_d = '0;
      case (nxt_state)
         ST_ATTACK: begin
            if (attack_rate == '0 || att_sum[DATA_WIDTH])
               svc_level_d = '1;
            else
               svc_level_d = att_sum[DATA_WIDTH-1:0];
            if (svc_level_d == '1)
               svc_state_d = ST_DECAY;
         end
         ST_DECAY: begin
            if (decay_rate == '0 || dec_diff[DATA_WIDTH] ||
                dec_diff[DATA_WIDTH-1:0] <= sustain_level) begin
               svc_level_d = sustain_level;
               svc_state_d = ST_SUSTAIN;
            end else begin
               svc_level_d = dec_diff[DATA_WIDTH-1:0];
            end
         end
         ST_SUSTAIN: svc_level_d = sustain_level;
         ST_RELEASE: begin
            if (release_rate == '0 || rel_diff[DATA_WIDTH])
               svc_level_d = '0;
            else
               svc_level_d = rel_diff[DATA_WIDTH-1:0];
            if (svc_level_d == '0)
               svc_state_d = ST_IDLE;
         end
         default: begin
            svc_state_d = ST_IDLE;
            svc_level_d = '0;
         end
      endcase
   end

   // Active mask as it will stand after this cycle's update
   always_comb begin
      active_d = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         if (VOICE_W'(i) == ptr_q)
            active_d[i] = (svc_state_d != ST_IDLE);
         else
            active_d[i] = (state_q[i] != ST_IDLE);
      end
   end

   // Per-voice state update and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         prev_gate_q <= '0;
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            state_q[i] <= ST_IDLE;
            level_q[i] <= '0;
         end
         env_valid_q <= 1'b0;
         env_voice_q <= '0;
         env_level_q <= '0;
         active_q    <= '0;
      end else begin
         ptr_q                <= ptr_d;
         prev_gate_q[ptr_q]   <= g;
         state_q[ptr_q]       <= svc_state_d;
         level_q[ptr_q]       <= svc_level_d;
         env_valid_q          <= 1'b1;
         env_voice_q          <= ptr_q;
         env_level_q          <= svc_level_d;
         active_q             <= active_d;
      end
   end

   assign env_valid = env_valid_q;
   assign env_voice = env_voice_q;
   assign env_level = env_level_q;
   assign active    = active_q;

endmodule

// File: tb/tb_adsr_env_mux.sv
// Bench for adsr_env_mux: retrigger and legato instances share stimulus;
// table of per-service expectations plus hand-written reset/simultaneous sequences.
module tb_adsr_env_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  gate;
   logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;

   logic        env_valid,   env_valid_l;
   logic [1:0]  env_voice,   env_voice_l;
   logic [15:0] env_level,   env_level_l;
   logic [3:0]  active,      active_l;

   adsr_env_mux #(.DATA_WIDTH(16), .NUM_VOICES(4), .RETRIGGER(1)) dut (
      .clk(clk), .rst(rst), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_level(sustain_level), .release_rate(release_rate),
      .env_valid(env_valid), .env_voice(env_voice),
      .env_level(env_level), .active(active)
   );

   adsr_env_mux #(.DATA_WIDTH(16), .NUM_VOICES(4), .RETRIGGER(0)) dut_l (
      .clk(clk), .rst(rst), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_level(sustain_level), .release_rate(release_rate),
      .env_valid(env_valid_l), .env_voice(env_voice_l),
      .env_level(env_level_l), .active(active_l)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  gate;
      logic [15:0] att, dec, sus, rel;
      int unsigned voice;
      logic [15:0] lvl, lvl_l;
      logic [3:0]  act;
   } vec_t;

   typedef struct {
      int unsigned voice;
      bit          chk_level;
      logic [15:0] lvl, lvl_l;
      logic [3:0]  act;
   } exp_t;

   exp_t        sb[$];
   vec_t        vt[$];
   int unsigned tb_ptr;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic vec_t mk(input logic [3:0] g, input logic [15:0] a, d, s, r,
                               input int unsigned v, input logic [15:0] l, ll,
                               input logic [3:0] act);
      vec_t x;
      x.gate = g; x.att = a; x.dec = d; x.sus = s; x.rel = r;
      x.voice = v; x.lvl = l; x.lvl_l = ll; x.act = act;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] g, input logic [15:0] a, d, s, r);
      gate = g; attack_rate = a; decay_rate = d; sustain_level = s; release_rate = r;
   endtask

   // One clock of service: push the expectation, clock, then pop and compare.
   task automatic step(input bit chk_level, input logic [15:0] l, ll, input logic [3:0] act);
      exp_t e;
      e.voice = tb_ptr; e.chk_level = chk_level; e.lvl = l; e.lvl_l = ll; e.act = act;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk("env_valid",   32'(env_valid),   32'd1);
      chk("env_voice",   32'(env_voice),   32'(e.voice));
      chk("env_valid_l", 32'(env_valid_l), 32'd1);
      chk("env_voice_l", 32'(env_voice_l), 32'(e.voice));
      if (e.chk_level) begin
         chk("env_level",   32'(env_level),   32'(e.lvl));
         chk("env_level_l", 32'(env_level_l), 32'(e.lvl_l));
         chk("active",      32'(active),      32'(e.act));
         chk("active_l",    32'(active_l),    32'(e.act));
      end
      tb_ptr = (tb_ptr + 1) % 4;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"},   32'(env_valid),   32'd0);
      chk({tag, "_voice"},   32'(env_voice),   32'd0);
      chk({tag, "_level"},   32'(env_level),   32'd0);
      chk({tag, "_active"},  32'(active),      32'd0);
      chk({tag, "_valid_l"}, 32'(env_valid_l), 32'd0);
      chk({tag, "_active_l"},32'(active_l),    32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // gate, att, dec, sus, rel, voice, level(retrigger), level(legato), active
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'h4000, 16'h4000, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'h8000, 16'h8000, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hC000, 16'hC000, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hFFFF, 16'hFFFF, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hEFFF, 16'hEFFF, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hDFFF, 16'hDFFF, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hCFFF, 16'hCFFF, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hC000, 16'hC000, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'hC000, 16'hC000, 4'b0001));
      vt.push_back(mk(4'b0000, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'h7000, 16'h7000, 4'b0001));
      vt.push_back(mk(4'b0000, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'h2000, 16'h2000, 4'b0001));
      vt.push_back(mk(4'b0000, 16'h4000, 16'h1000, 16'hC000, 16'h5000, 0, 16'h0000, 16'h0000, 4'b0000));
      vt.push_back(mk(4'b0100, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 2, 16'hFFFF, 16'hFFFF, 4'b0100));
      vt.push_back(mk(4'b0100, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 2, 16'h8000, 16'h8000, 4'b0100));
      vt.push_back(mk(4'b0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 2, 16'h0000, 16'h0000, 4'b0000));
      vt.push_back(mk(4'b0001, 16'h0000, 16'h0000, 16'hC000, 16'h5000, 0, 16'hFFFF, 16'hFFFF, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h0000, 16'h0000, 16'hC000, 16'h5000, 0, 16'hC000, 16'hC000, 4'b0001));
      vt.push_back(mk(4'b0000, 16'h0000, 16'h0000, 16'hC000, 16'h5000, 0, 16'h7000, 16'h7000, 4'b0001));
      vt.push_back(mk(4'b0001, 16'h1000, 16'h0000, 16'hC000, 16'h5000, 0, 16'h1000, 16'h8000, 4'b0001));
      vt.push_back(mk(4'b0011, 16'h0000, 16'h0000, 16'hC000, 16'h5000, 1, 16'hFFFF, 16'hFFFF, 4'b0011));
      vt.push_back(mk(4'b0011, 16'h0000, 16'h0000, 16'hC000, 16'h5000, 1, 16'hC000, 16'hC000, 4'b0011));
      vt.push_back(mk(4'b0001, 16'h0000, 16'h0000, 16'hC000, 16'h5000, 1, 16'h7000, 16'h7000, 4'b0011));
      vt.push_back(mk(4'b0011, 16'h1000, 16'h0000, 16'hC000, 16'h8000, 1, 16'h1000, 16'h8000, 4'b0011));
      vt.push_back(mk(4'b0011, 16'h0000, 16'h1000, 16'hFFFF, 16'h8000, 1, 16'hFFFF, 16'hFFFF, 4'b0011));
      vt.push_back(mk(4'b0011, 16'h0000, 16'h1000, 16'hFFFF, 16'h8000, 1, 16'hFFFF, 16'hFFFF, 4'b0011));
      vt.push_back(mk(4'b0011, 16'h0000, 16'h1000, 16'h0000, 16'h8000, 1, 16'h0000, 16'h0000, 4'b0011));
      vt.push_back(mk(4'b0011, 16'h0000, 16'h1000, 16'h0000, 16'h8000, 1, 16'h0000, 16'h0000, 4'b0011));

      // Reset state
      rst = 1'b1;
      drive(4'b0000, '0, '0, '0, '0);
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tb_ptr = 0;

      // Table: each record is the next service of its voice
      foreach (vt[k]) begin
         drive(vt[k].gate, vt[k].att, vt[k].dec, vt[k].sus, vt[k].rel);
         for (int n = 0; n < 4 && tb_ptr != vt[k].voice; n++)
            step(1'b0, '0, '0, '0);
         step(1'b1, vt[k].lvl, vt[k].lvl_l, vt[k].act);
      end

      // All four gates rise together; attack rate changes per service
      rst = 1'b1;
      drive(4'b0000, '0, '0, '0, '0);
      tick();
      check_reset_outputs("reset2");
      rst = 1'b0;
      tb_ptr = 0;
      drive(4'b1111, 16'h1000, 16'h0000, 16'hC000, 16'h0000);
      step(1'b1, 16'h1000, 16'h1000, 4'b0001);
      attack_rate = 16'h2000;
      step(1'b1, 16'h2000, 16'h2000, 4'b0011);
      attack_rate = 16'h3000;
      step(1'b1, 16'h3000, 16'h3000, 4'b0111);
      attack_rate = 16'h4000;
      step(1'b1, 16'h4000, 16'h4000, 4'b1111);
      attack_rate = 16'h1000;
      step(1'b1, 16'h2000, 16'h2000, 4'b1111);

      // Put voices 1,2 into RELEASE and voice 3 into DECAY
      drive(4'b1001, 16'h0000, 16'h1000, 16'h8000, 16'h0800);
      step(1'b1, 16'h1800, 16'h1800, 4'b1111);
      step(1'b1, 16'h2800, 16'h2800, 4'b1111);
      step(1'b1, 16'hFFFF, 16'hFFFF, 4'b1111);

      // One-cycle reset mid-envelope, gate[0] held high through it
      drive(4'b0001, 16'h4000, 16'h1000, 16'h8000, 16'h0800);
      rst = 1'b1;
      tick();
      check_reset_outputs("midreset");
      rst = 1'b0;
      tb_ptr = 0;
      step(1'b1, 16'h4000, 16'h4000, 4'b0001);
      step(1'b1, 16'h0000, 16'h0000, 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adsr_env_mux.md
# adsr_env_mux

Time-multiplexed, multi-voice ADSR envelope generator for the polyphonic synth core. It supersedes the single-voice attack/decay/release envelope by adding a true release rate, an explicit SUSTAIN state, rate-0 "instant" segments and a legato/retrigger mode. One shared saturating add/sub datapath services NUM_VOICES voices round-robin, one voice per clock. It emits a voice-tagged level stream consumed by the per-voice VCA multiplier.

## Interface
- DATA_WIDTH, 16: envelope level and rate width, unsigned.
- NUM_VOICES, 4: voice count, ≥2.
- RETRIGGER, 1: 1 = a note-on restarts from 0; 0 = legato, a note-on resumes ATTACK from the current level.
- VOICE_W, $clog2(NUM_VOICES): localparam, voice index width.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- gate  in  NUM_VOICES  per-voice note gate; bit v is sampled only in voice v's service cycle.
- attack_rate  in  DATA_WIDTH  increment per service; 0 = instant.
- decay_rate  in  DATA_WIDTH  decrement per service; 0 = instant.
- sustain_level  in  DATA_WIDTH  sustain target, shared by all voices.
- release_rate  in  DATA_WIDTH  decrement per service; 0 = instant.
- env_valid  out  1  env_voice/env_level valid this cycle.
- env_voice  out  VOICE_W  voice index of env_level.
- env_level  out  DATA_WIDTH  updated level of env_voice.
- active  out  NUM_VOICES  bit v = 1 when voice v state ≠ IDLE.

## Operation
- Per-voice storage: state (3 bits), level (DATA_WIDTH), prev_gate (1). ptr counts 0..NUM_VOICES-1 and wraps to 0.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Other encodings go to IDLE with level 0.
- Each cycle only voice v = ptr is serviced.
- rise = gate[v] & ~prev_gate[v]; fall = ~gate[v]. Set prev_gate[v] ← gate[v].
- Next-state priority, highest first:
  - rise in any state → ATTACK. If RETRIGGER=1, start level = 0; otherwise start level = current level.
  - fall in ATTACK, DECAY or SUSTAIN → RELEASE.
  - Otherwise keep the current state.
- In the same service, apply the action of the next state to the start level:
  - ATTACK: level = sat_add(level, attack_rate). attack_rate = 0 forces MAX. If the result is MAX, state → DECAY.
  - DECAY: if decay_rate = 0, or level − decay_rate ≤ sustain_level (including underflow), set level = sustain_level and state → SUSTAIN. Otherwise level −= decay_rate.
  - SUSTAIN: level = sustain_level; it tracks live changes.
  - RELEASE: level = sat_sub(level, release_rate). release_rate = 0 forces 0. A result of 0 → IDLE.
  - IDLE: level = 0.
- Saturation: sat_add is computed DATA_WIDTH+1 wide and clamps to MAX = all ones. sat_sub clamps to 0.
- sustain_level = MAX: DECAY completes in one service. sustain_level = 0: voice holds at 0 in SUSTAIN until the gate falls.
- A gate pulse that opens and closes entirely between two services of its voice is not seen.
- A high-low-high between services is seen as still high, so no retrigger.

## Timing
- Reset: ptr=0, all state=IDLE, all level=0, all prev_gate=0; env_valid=0, env_voice=0, env_level=0, active=0.
- First cycle after rst deasserts: voice 0 is serviced. Output registers update at the end of that cycle.
- Latency: the service in cycle N appears on env_* in cycle N+1. env_level is the post-update level.
- env_valid = 1 every cycle after the first post-reset service.
- active bits update in the same cycle as env_*.
- Each voice is serviced every NUM_VOICES cycles. Per-voice envelope time = steps × NUM_VOICES clocks.
- Rate and sustain inputs are sampled in the service cycle. Changes apply to subsequently serviced voices with no glitch hold.
- A gate held high through reset counts as a rise at its first service.
- rst mid-envelope: all voices drop to IDLE/0 on the next edge, with no release tail.

## Test plan
- Attack/decay/sustain, DATA_WIDTH=16, NUM_VOICES=4, RETRIGGER=1: attack=0x4000, decay=0x1000, sustain=0xC000, gate[0] high.
  - Voice-0 outputs: 0x4000, 0x8000, 0xC000, 0xFFFF (state DECAY), then 0xEFFF, 0xDFFF, 0xCFFF, then 0xC000 (SUSTAIN) held.
  - Each voice-0 sample is 4 cycles apart; active=4'b0001.
- Release: from sustain 0xC000, release=0x5000, gate[0] low.
  - Outputs: 0x7000, 0x2000, 0x0000. active[0] clears on the 0x0000 sample.
- Instant rates: all rates 0, sustain=0x8000, gate[2] high.
  - Voice-2 outputs: 0xFFFF, then 0x8000.
  - Then gate[2] low → 0x0000 with IDLE on the next voice-2 service.
- Retrigger vs legato:
  - Note-on in RELEASE at level 0x7000, attack=0x1000.
  - RETRIGGER=1 → next sample 0x1000. RETRIGGER=0 → next sample 0x8000.
- Simultaneous events and priority:
  - All 4 gates high in the same cycle: env_voice sequence 0,1,2,3,0 with independent levels.
  - Voice 1 rises in the same service where RELEASE would reach 0: goes to ATTACK, not IDLE.
- Reset mid-operation: rst for one cycle while 3 voices are in DECAY/RELEASE.
  - Next cycle: env_valid=0, active=0. The following output is voice 0.
